// File: rtl/dff_mem_ctrl.sv
// Flip-flop register-file scratch memory with valid/ready requests, registered read responses
// and a clear sweep that zeroes every word. Optional byte enables via DFF_MEM_BYTE_WE_EN.
//
// state | meaning
// CLEAR | sweep writes zero to one word per cycle; requests blocked, busy high
// IDLE  | accepts single-word reads and writes; clr restarts the sweep
module dff_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic                                          req_we,
  input  logic [ADDR_W-1:0]                             req_addr,
  input  logic [DATA_W-1:0]                             req_wdata,
  input  logic [((DATA_W/8 > 0) ? DATA_W/8 : 1)-1:0]    req_be,
  input  logic                                          clr,
  output logic                                          busy,
  output logic                                          rsp_valid,
  output logic [DATA_W-1:0]                             rsp_rdata,
  output logic                                          rsp_err
);

  localparam int              BE_W    = (DATA_W/8 > 0) ? DATA_W/8 : 1;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             in_range;
  logic             accept;
  logic [IDX_W-1:0] addr_idx;
  logic [IDX_W-1:0] ptr_idx;

  assign in_range  = {1'b0, req_addr} < DEPTH_C;
  assign req_ready = (state == IDLE) && !clr;
  assign accept    = req_valid && req_ready;
  assign addr_idx  = req_addr[IDX_W-1:0];
  assign ptr_idx   = ptr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      ptr       <= '0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_C) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end else if (accept && !req_we) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !in_range;
            rsp_rdata <= in_range ? mem[addr_idx] : '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage is never reset directly; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[ptr_idx] <= '0;
      end else if (accept && req_we && in_range) begin
`ifdef DFF_MEM_BYTE_WE_EN
        for (int i = 0; i < BE_W; i++) begin
          if (req_be[i]) mem[addr_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
`else
        mem[addr_idx] <= req_wdata;
`endif
      end
    end
  end

`ifndef DFF_MEM_BYTE_WE_EN
  // Byte enables stay on the port list for pin compatibility only.
  logic unused_be;
  assign unused_be = ^req_be;
`endif

endmodule

// File: tb/tb_dff_mem_ctrl.sv
// Self-checking bench for dff_mem_ctrl: default 8x16 instance plus a 16-bit, 12-word instance
// for out-of-range and byte-enable behaviour (expectations follow DFF_MEM_BYTE_WE_EN).
module tb_dff_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst;
  logic       req_valid, req_ready, req_we, clr, busy, rsp_valid, rsp_err;
  logic [3:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  logic [0:0] req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_clr, b_busy, b_rsp_valid, b_rsp_err;
  logic [3:0]  b_req_addr;
  logic [15:0] b_req_wdata, b_rsp_rdata;
  logic [1:0]  b_req_be;

  dff_mem_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .clr(clr), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dff_mem_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be), .clr(b_clr), .busy(b_busy),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

`ifdef DFF_MEM_BYTE_WE_EN
  localparam logic [15:0] EXP_BE_HI   = 16'hAB34;
  localparam logic [15:0] EXP_BE_NONE = 16'hAB34;
`else
  localparam logic [15:0] EXP_BE_HI   = 16'hABCD;
  localparam logic [15:0] EXP_BE_NONE = 16'hFFFF;
`endif

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       exp_valid;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_do(input logic we, input logic [3:0] addr, input logic [7:0] wd);
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic a_read(input string nm, input logic [3:0] addr, input logic [7:0] exp_d);
    a_do(1'b0, addr, 8'h00);
    chk({nm, "_valid"}, rsp_valid, 1);
    chk({nm, "_data"}, rsp_rdata, exp_d);
    chk({nm, "_err"}, rsp_err, 0);
  endtask

  task automatic b_do(input logic we, input logic [3:0] addr, input logic [15:0] wd, input logic [1:0] be);
    b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_be = be; b_req_valid = 1'b1;
    step();
    b_req_valid = 1'b0;
  endtask

  task automatic b_read(input string nm, input logic [3:0] addr, input logic [15:0] exp_d, input logic exp_e);
    b_do(1'b0, addr, 16'h0000, 2'b00);
    chk({nm, "_valid"}, b_rsp_valid, 1);
    chk({nm, "_data"}, b_rsp_rdata, exp_d);
    chk({nm, "_err"}, b_rsp_err, exp_e);
  endtask

  // Counts sampled cycles with busy high; optionally pulses clr on one of them.
  task automatic count_busy(input int clr_at, output int cnt, output logic saw_rsp);
    int k;
    k = 0; cnt = 0; saw_rsp = 1'b0;
    while (busy && k < 100) begin
      cnt++; k++;
      if (rsp_valid) saw_rsp = 1'b1;
      clr = (cnt == clr_at);
      step();
    end
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         cnt, nb, k;
    logic       saw;
    int         busy_left;
    logic [7:0] mmem [16];
    logic [7:0] last_rd;
    logic       hold, acc, exp_v, exp_ready;

    rst = 1'b1; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    b_clr = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;

    // Reset values and sweep length.
    step();
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_b_busy", b_busy, 1);
    rst = 1'b0;
    cnt = 0; nb = 0; k = 0;
    while (busy && k < 100) begin
      cnt++; k++;
      if (b_busy) nb++;
      step();
    end
    chk("sweep_len", cnt, 16);
    chk("b_sweep_len", nb, 12);
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    chk("b_idle_busy", b_busy, 0);

    // Out-of-range and byte enables on the 16-bit, 12-word instance.
    b_do(1'b1, 4'd2, 16'h1234, 2'b11);
    b_do(1'b1, 4'd2, 16'hABCD, 2'b10);
    b_read("b_be_hi", 4'd2, EXP_BE_HI, 1'b0);
    b_do(1'b1, 4'd2, 16'hFFFF, 2'b00);
    b_read("b_be_none", 4'd2, EXP_BE_NONE, 1'b0);
    b_do(1'b1, 4'd13, 16'h0077, 2'b11);
    b_read("b_oor13", 4'd13, 16'h0000, 1'b1);
    step();
    chk("b_idle_valid", b_rsp_valid, 0);
    chk("b_idle_err", b_rsp_err, 0);
    chk("b_hold_rdata", b_rsp_rdata, 0);
    b_read("b_last_word_prior", 4'd11, 16'h0000, 1'b0);
    b_do(1'b1, 4'd11, 16'h5555, 2'b11);
    b_read("b_last_word", 4'd11, 16'h5555, 1'b0);
    b_read("b_oor15", 4'd15, 16'h0000, 1'b1);

    // Table-driven streaming on the default instance.
    for (int a = 0; a < 16; a++) vecs.push_back('{1'b0, 4'(a), 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 4'd3,  8'hA5, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 4'd15, 8'h3C, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 4'd3,  8'h00, 1'b1, 8'hA5});
    vecs.push_back('{1'b0, 4'd15, 8'h00, 1'b1, 8'h3C});
    vecs.push_back('{1'b0, 4'd3,  8'h00, 1'b1, 8'hA5});
    vecs.push_back('{1'b1, 4'd3,  8'h5A, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 4'd3,  8'h00, 1'b1, 8'h5A});
    for (int i = 0; i < vecs.size(); i++) begin
      req_we = vecs[i].we; req_addr = vecs[i].addr; req_wdata = vecs[i].wdata; req_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_ready", i), req_ready, 1);
      step();
      chk($sformatf("vec%0d_valid", i), rsp_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), rsp_err, 0);
    end
    req_valid = 1'b0;
    step();
    chk("stream_end_valid", rsp_valid, 0);
    chk("stream_hold_rdata", rsp_rdata, 8'h5A);

    // clr wins over a concurrent read; a clr pulse mid-sweep does not extend it.
    a_do(1'b1, 4'd7, 8'hFF);
    clr = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
    #1;
    chk("clr_ready", req_ready, 0);
    step();
    clr = 1'b0; req_valid = 1'b0;
    chk("clr_no_rsp", rsp_valid, 0);
    chk("clr_busy", busy, 1);
    count_busy(4, cnt, saw);
    chk("clr_sweep_len", cnt, 16);
    chk("clr_sweep_no_rsp", saw, 0);
    a_read("clr_read7", 4'd7, 8'h00);

    // Reset on the same edge as a read, then again mid-sweep.
    a_do(1'b1, 4'd9, 8'h42);
    req_we = 1'b0; req_addr = 4'd9; req_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; req_valid = 1'b0;
    chk("rst_read_no_rsp", rsp_valid, 0);
    chk("rst_read_busy", busy, 1);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_ready", req_ready, 0);
    count_busy(-1, cnt, saw);
    chk("rst_mid_sweep_len", cnt, 16);
    a_read("rst_read9", 4'd9, 8'h00);

    // Randomized traffic against a word-array model of the memory.
    for (int a = 0; a < 16; a++) mmem[a] = 8'h00;
    last_rd = 8'h00;
    busy_left = 0;
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 4'($urandom);
        req_wdata = 8'($urandom);
      end
      clr = ($urandom_range(0, 39) == 0);
      #1;
      exp_ready = (busy_left == 0) && !clr;
      chk("rnd_ready", req_ready, exp_ready);
      chk("rnd_busy", busy, busy_left != 0);
      acc  = req_valid && exp_ready;
      hold = req_valid && !acc;
      exp_v = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
      end else if (clr) begin
        busy_left = 16;
        for (int a = 0; a < 16; a++) mmem[a] = 8'h00;
      end else if (acc) begin
        if (req_we) mmem[req_addr] = req_wdata;
        else begin
          exp_v = 1'b1;
          last_rd = mmem[req_addr];
        end
      end
      step();
      chk("rnd_valid", rsp_valid, exp_v);
      chk("rnd_rdata", rsp_rdata, last_rd);
      chk("rnd_err", rsp_err, 0);
    end
    clr = 1'b0; req_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
